btn_press_repeat: RTL and testbench
===================================

// Module: btn_press_repeat
// PURPOSE
//  Front-end for board push-buttons/switches ahead of the test frames and CPU IO.
//  Per channel: 2-FF synchronizer, ms-granular debounce, then one-cycle press/release
//  pulses plus keyboard-style auto-repeat, so test frames see clean single-shot
//  commands (cs/we) instead of raw levels. One shared 1 ms tick serves all channels.
// PARAMETERS
//  CLK_FREQ     100          clock frequency in MHz
//  TICK_CYCLES  CLK_FREQ*1000  cycles per ms tick; benches override for short sims
//  N            4            number of button channels
//  DEBOUNCE_MS  10           ms input must be stable before level is accepted (>=1)
//  DELAY_MS     500          hold time from accepted press to first repeat (>=1)
//  RATE_MS      100          period between subsequent repeats (>=1)
// PORTS
//  clk        in   1   system clock, all logic on posedge
//  rst        in   1   synchronous reset, active-high
//  btn_i      in   N   raw button levels, asynchronous, 1 = pressed
//  hold_o     out  N   debounced level
//  press_o    out  N   1-cycle pulse on accepted 0->1
//  release_o  out  N   1-cycle pulse on accepted 1->0
//  repeat_o   out  N   1-cycle auto-repeat pulse while held
//  event_o    out  N   press_o | repeat_o (typematic stream)
// BEHAVIOUR
//  Reset: all outputs 0; sync flops, debounced level, counters 0; FSM IDLE; prescaler 0.
//  Reset mid-operation: everything returns to reset state next cycle, no pulse emitted.
//  Tick: prescaler counts 0..TICK_CYCLES-1, wraps; tick=1 for one cycle at wrap.
//  Sync: s1<=btn_i, s2<=s1 (2 cycles latency); later stages use s2 only.
//  Debounce (per ch): if s2==lvl, dcnt<=0; else on tick: dcnt==DEBOUNCE_MS-1 ->
//   lvl<=s2, dcnt<=0; otherwise dcnt++. Any bounce back clears dcnt.
//   Acceptance latency: DEBOUNCE_MS-1..DEBOUNCE_MS ms after s2 settles.
//  hold_o=lvl (registered). press_o/release_o registered, asserted cycle after lvl edge.
//  Repeat FSM (per ch), rcnt counts ticks:
//   IDLE  : lvl rises -> WAIT, rcnt<=0.
//   WAIT  : on tick, rcnt==DELAY_MS-1 -> repeat pulse, RPT, rcnt<=0; else rcnt++.
//   RPT   : on tick, rcnt==RATE_MS-1 -> repeat pulse, rcnt<=0; else rcnt++.
//   any   : lvl falls -> IDLE, rcnt<=0; no repeat that cycle (fall has priority over tick).
//  repeat_o aligned with press_o timing (registered, 1 cycle after FSM decision).
//  press_o and repeat_o never coincide on one channel; channels fully independent,
//  several channels may pulse in same cycle.
//  Counters 16 bits; parameters must fit (elaborate-time check, $error if not).
//  Prescaler width $clog2(TICK_CYCLES); TICK_CYCLES=1 -> tick every cycle.
// STRUCTURE
//  Top: prescaler + generate loop of N btn_press_chan instances (sync, debounce, FSM).
//  Shared include: FSM state encodings (IDLE/WAIT/RPT) and counter width constant,
//  added to define.vh; no other shared types.
// TESTING (TICK_CYCLES=10, DEBOUNCE_MS=3, DELAY_MS=5, RATE_MS=2, N=4)
//  Reset asserted 5 cycles with btn_i=4'hF -> all outputs 0 throughout and 1 cycle after.
//  btn_i[0] high 15 cycles then low -> no press_o, hold_o stays 0 (glitch rejected).
//  btn_i[1] held 200 cycles -> press_o[1] exactly once 22..34 cycles after edge; first
//   repeat_o[1] 50 cycles after press, then every 20 cycles; event_o[1] = union.
//  Release ch1 after 2nd repeat -> release_o[1] once 22..34 cycles later, no further repeats.
//  Chattering input (toggle every 7 cycles for 100 cycles, then high) -> single press_o,
//   timed from final settle.
//  btn_i=4'hF simultaneously -> identical pulse trains on all 4 channels; rst asserted
//   during RPT -> pulses stop, re-press after reset gives fresh press and 50-cycle delay.

Source files
------------

// File: rtl/btn_press_repeat_pkg.sv
// rtl/btn_press_repeat_pkg.sv - shared repeat-FSM encoding and counter width
// Purpose: common constants/types for the button front-end.
// Contents: CNT_W (debounce/repeat counter width), cnt_t, rpt_state_e.
package btn_press_repeat_pkg;

  localparam int CNT_W = 16;

  typedef logic [CNT_W-1:0] cnt_t;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_RPT  = 2'd2
  } rpt_state_e;

endpackage

// File: rtl/btn_press_repeat_chan.sv
// rtl/btn_press_repeat_chan.sv - one button channel: sync, debounce, press/release/repeat
// Purpose: turns one raw asynchronous button level into clean single-cycle pulses.
// Ports:
//   clk, rst   : clock, synchronous active-high reset
//   tick_i     : shared 1 ms tick (one cycle wide)
//   btn_i      : raw button level, 1 = pressed
//   hold_o     : debounced level
//   press_o    : 1-cycle pulse on accepted 0->1
//   release_o  : 1-cycle pulse on accepted 1->0
//   repeat_o   : 1-cycle auto-repeat pulse while held
module btn_press_repeat_chan
  import btn_press_repeat_pkg::*;
#(
  parameter int DEBOUNCE_MS = 10,
  parameter int DELAY_MS    = 500,
  parameter int RATE_MS     = 100
) (
  input  logic clk,
  input  logic rst,
  input  logic tick_i,
  input  logic btn_i,
  output logic hold_o,
  output logic press_o,
  output logic release_o,
  output logic repeat_o
);

  localparam cnt_t DEB_LAST  = cnt_t'(DEBOUNCE_MS - 1);
  localparam cnt_t DLY_LAST  = cnt_t'(DELAY_MS - 1);
  localparam cnt_t RATE_LAST = cnt_t'(RATE_MS - 1);

  logic       s1_q, s2_q;
  logic       lvl_q, lvl_d;
  cnt_t       dcnt_q, dcnt_d;
  cnt_t       rcnt_q, rcnt_d;
  rpt_state_e state_q, state_d;
  logic       press_q, release_q, repeat_q;
  logic       rise, fall, rpt_d;

  // Debounce: the synchronized level must disagree with the accepted level
  // across DEBOUNCE_MS consecutive ticks; any agreement restarts the count.
  always_comb begin
    lvl_d  = lvl_q;
    dcnt_d = dcnt_q;
    if (s2_q == lvl_q) begin
      dcnt_d = '0;
    end else if (tick_i) begin
      if (dcnt_q == DEB_LAST) begin
        lvl_d  = s2_q;
        dcnt_d = '0;
      end else begin
        dcnt_d = dcnt_q + cnt_t'(1);
      end
    end
  end

  // Edges are taken on the next-state level so press/repeat/release all come
  // out of registers with the same one-cycle alignment.
  assign rise = lvl_d & ~lvl_q;
  assign fall = ~lvl_d & lvl_q;

  // Repeat FSM; a falling level wins over a coincident repeat tick.
  always_comb begin
    state_d = state_q;
    rcnt_d  = rcnt_q;
    rpt_d   = 1'b0;
    if (fall) begin
      state_d = ST_IDLE;
      rcnt_d  = '0;
    end else begin
      unique case (state_q)
        ST_IDLE: begin
          if (rise) begin
            state_d = ST_WAIT;
            rcnt_d  = '0;
          end
        end
        ST_WAIT: begin
          if (tick_i) begin
            if (rcnt_q == DLY_LAST) begin
              rpt_d   = 1'b1;
              state_d = ST_RPT;
              rcnt_d  = '0;
            end else begin
              rcnt_d = rcnt_q + cnt_t'(1);
            end
          end
        end
        ST_RPT: begin
          if (tick_i) begin
            if (rcnt_q == RATE_LAST) begin
              rpt_d  = 1'b1;
              rcnt_d = '0;
            end else begin
              rcnt_d = rcnt_q + cnt_t'(1);
            end
          end
        end
        default: begin
          state_d = ST_IDLE;
          rcnt_d  = '0;
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      s1_q      <= 1'b0;
      s2_q      <= 1'b0;
      lvl_q     <= 1'b0;
      dcnt_q    <= '0;
      rcnt_q    <= '0;
      state_q   <= ST_IDLE;
      press_q   <= 1'b0;
      release_q <= 1'b0;
      repeat_q  <= 1'b0;
    end else begin
      s1_q      <= btn_i;
      s2_q      <= s1_q;
      lvl_q     <= lvl_d;
      dcnt_q    <= dcnt_d;
      rcnt_q    <= rcnt_d;
      state_q   <= state_d;
      press_q   <= rise;
      release_q <= fall;
      repeat_q  <= rpt_d;
    end
  end

  assign hold_o    = lvl_q;
  assign press_o   = press_q;
  assign release_o = release_q;
  assign repeat_o  = repeat_q;

endmodule

// File: rtl/btn_press_repeat.sv
// rtl/btn_press_repeat.sv - N-channel debounced button front-end with auto-repeat
// Purpose: shared 1 ms prescaler plus one btn_press_repeat_chan per button.
// Ports:
//   clk, rst   : clock, synchronous active-high reset
//   btn_i      : N raw button levels, 1 = pressed
//   hold_o     : N debounced levels
//   press_o    : N 1-cycle pulses on accepted press
//   release_o  : N 1-cycle pulses on accepted release
//   repeat_o   : N 1-cycle auto-repeat pulses
//   event_o    : press_o | repeat_o (typematic stream)
module btn_press_repeat
  import btn_press_repeat_pkg::*;
#(
  parameter int CLK_FREQ    = 100,
  parameter int TICK_CYCLES = CLK_FREQ * 1000,
  parameter int N           = 4,
  parameter int DEBOUNCE_MS = 10,
  parameter int DELAY_MS    = 500,
  parameter int RATE_MS     = 100
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [N-1:0] btn_i,
  output logic [N-1:0] hold_o,
  output logic [N-1:0] press_o,
  output logic [N-1:0] release_o,
  output logic [N-1:0] repeat_o,
  output logic [N-1:0] event_o
);

  localparam int PW = (TICK_CYCLES > 1) ? $clog2(TICK_CYCLES) : 1;
  localparam logic [PW-1:0] PCNT_LAST = PW'(TICK_CYCLES - 1);

  if (TICK_CYCLES < 1) begin : g_bad_tick
    $error("btn_press_repeat: TICK_CYCLES must be >= 1");
  end
  if (DEBOUNCE_MS < 1 || DEBOUNCE_MS > 2**CNT_W) begin : g_bad_deb
    $error("btn_press_repeat: DEBOUNCE_MS out of counter range");
  end
  if (DELAY_MS < 1 || DELAY_MS > 2**CNT_W) begin : g_bad_dly
    $error("btn_press_repeat: DELAY_MS out of counter range");
  end
  if (RATE_MS < 1 || RATE_MS > 2**CNT_W) begin : g_bad_rate
    $error("btn_press_repeat: RATE_MS out of counter range");
  end

  logic [PW-1:0] pcnt_q, pcnt_d;
  logic          tick;

  // With TICK_CYCLES == 1 the counter sits at 0 and tick is permanently high.
  assign tick   = (pcnt_q == PCNT_LAST);
  assign pcnt_d = tick ? '0 : pcnt_q + PW'(1);

  always_ff @(posedge clk) begin
    if (rst) begin
      pcnt_q <= '0;
    end else begin
      pcnt_q <= pcnt_d;
    end
  end

  for (genvar g = 0; g < N; g++) begin : g_chan
    btn_press_repeat_chan #(
      .DEBOUNCE_MS(DEBOUNCE_MS),
      .DELAY_MS   (DELAY_MS),
      .RATE_MS    (RATE_MS)
    ) u_chan (
      .clk      (clk),
      .rst      (rst),
      .tick_i   (tick),
      .btn_i    (btn_i[g]),
      .hold_o   (hold_o[g]),
      .press_o  (press_o[g]),
      .release_o(release_o[g]),
      .repeat_o (repeat_o[g])
    );
  end

  assign event_o = press_o | repeat_o;

endmodule

// File: tb/tb_btn_press_repeat.sv
// tb/tb_btn_press_repeat.sv - scoreboard bench for btn_press_repeat
module tb_btn_press_repeat;
  localparam int N = 4, TICK = 10, DEB = 3, DLY = 5, RATE = 2;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic [N-1:0] btn = '1;
  logic [N-1:0] hold, press, rel, rpt, evt;

  always #5 clk = ~clk;

  btn_press_repeat #(
    .CLK_FREQ(100), .TICK_CYCLES(TICK), .N(N),
    .DEBOUNCE_MS(DEB), .DELAY_MS(DLY), .RATE_MS(RATE)
  ) dut (
    .clk(clk), .rst(rst), .btn_i(btn), .hold_o(hold), .press_o(press),
    .release_o(rel), .repeat_o(rpt), .event_o(evt)
  );

  typedef struct {
    int           cyc;
    logic [N-1:0] p, r, rp;
  } exp_t;
  typedef struct {
    string name;
    int    act, lo, hi;
  } dchk_t;

  exp_t  sb[$];
  dchk_t dq[$];
  int    cyc = 0;

  // Reference model: level accepted once the synchronized input has disagreed
  // for DEB ticks; repeats fall on press + DLY*TICK + k*RATE*TICK while held.
  logic [N-1:0] m_s1 = '0, m_s2 = '0, m_lvl = '0;
  int           m_mis[N];
  int           m_pe[N];
  int           m_rel = 0;

  function automatic int ticks_in(input int a, input int b);
    return (b + 1) / TICK - a / TICK;
  endfunction

  always @(posedge clk) begin
    exp_t e;
    logic tk;
    int   d;
    cyc++;
    e.cyc = cyc; e.p = '0; e.r = '0; e.rp = '0;
    if (rst) begin
      m_s1 = '0; m_s2 = '0; m_lvl = '0; m_rel = 0;
      for (int c = 0; c < N; c++) begin m_mis[c] = -1; m_pe[c] = 0; end
    end else begin
      tk = ((m_rel % TICK) == TICK - 1);
      for (int c = 0; c < N; c++) begin
        if (m_s2[c] == m_lvl[c]) m_mis[c] = -1;
        else begin
          if (m_mis[c] < 0) m_mis[c] = m_rel;
          if (tk && ticks_in(m_mis[c], m_rel) == DEB) begin
            m_mis[c] = -1;
            if (m_s2[c]) begin e.p[c] = 1'b1; m_pe[c] = m_rel; end
            else e.r[c] = 1'b1;
          end
        end
        if (m_lvl[c] && !e.r[c]) begin
          d = m_rel - m_pe[c] - DLY * TICK;
          if (d >= 0 && (d % (RATE * TICK)) == 0) e.rp[c] = 1'b1;
        end
      end
      m_lvl = (m_lvl | e.p) & ~e.r;
      m_s2  = m_s1;
      m_s1  = btn;
      m_rel++;
      if (|{e.p, e.r, e.rp}) sb.push_back(e);
    end
  end

  // Monitor: the only place comparisons are made and counted.
  int total = 0, passed = 0;
  int press_cnt[N], rep_cnt[N], rel_cnt[N];
  int last_press[N], last_rep[N], last_rel[N], first_rep_gap[N], rep_gap[N];

  initial begin
    for (int c = 0; c < N; c++) begin
      press_cnt[c] = 0; rep_cnt[c] = 0; rel_cnt[c] = 0; last_press[c] = 0;
      last_rep[c] = 0; last_rel[c] = 0; first_rep_gap[c] = -1; rep_gap[c] = -1;
    end
  end

  task automatic chk(input bit ok, input string name, input int act, input int lo, input int hi);
    total++;
    if (ok) passed++;
    else $display("FAIL %s at cycle %0d: actual %0d required %0d..%0d", name, cyc, act, lo, hi);
  endtask

  always @(negedge clk) begin
    exp_t         e;
    dchk_t        dc;
    logic [N-1:0] ep, er, erp;
    ep = '0; er = '0; erp = '0;
    while (sb.size() > 0 && sb[0].cyc < cyc) begin
      e = sb.pop_front();
      chk(1'b0, "missed_pulse_cycle", cyc, e.cyc, e.cyc);
    end
    if (sb.size() > 0 && sb[0].cyc == cyc) begin
      e = sb.pop_front();
      ep = e.p; er = e.r; erp = e.rp;
    end
    if (|{ep, er, erp, press, rel, rpt, evt}) begin
      chk(press == ep, "press_o", int'(press), int'(ep), int'(ep));
      chk(rel == er, "release_o", int'(rel), int'(er), int'(er));
      chk(rpt == erp, "repeat_o", int'(rpt), int'(erp), int'(erp));
      chk(evt == (ep | erp), "event_o", int'(evt), int'(ep | erp), int'(ep | erp));
    end
    chk(hold == m_lvl, "hold_o", int'(hold), int'(m_lvl), int'(m_lvl));
    for (int c = 0; c < N; c++) begin
      if (press[c] === 1'b1) begin
        press_cnt[c]++; last_press[c] = cyc; first_rep_gap[c] = -1;
      end
      if (rpt[c] === 1'b1) begin
        rep_cnt[c]++;
        if (first_rep_gap[c] < 0) first_rep_gap[c] = cyc - last_press[c];
        else rep_gap[c] = cyc - last_rep[c];
        last_rep[c] = cyc;
      end
      if (rel[c] === 1'b1) begin rel_cnt[c]++; last_rel[c] = cyc; end
    end
    while (dq.size() > 0) begin
      dc = dq.pop_front();
      chk(dc.act >= dc.lo && dc.act <= dc.hi, dc.name, dc.act, dc.lo, dc.hi);
    end
  end

  task automatic step(input int n);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  task automatic want(input string name, input int act, input int lo, input int hi);
    dchk_t d;
    d.name = name; d.act = act; d.lo = lo; d.hi = hi;
    dq.push_back(d);
  endtask

  initial begin
    int t0, b, br, bl, snap, i;
    int bp[N];
    int brp[N];
    int tmr[N];

    // reset held with all buttons pressed
    step(5);
    rst = 1'b0; btn = '0;
    step(2);
    want("reset_press_total", press_cnt[0] + press_cnt[1] + press_cnt[2] + press_cnt[3], 0, 0);

    // short glitch on ch0
    b = press_cnt[0];
    btn[0] = 1'b1; step(15); btn[0] = 1'b0; step(80);
    want("glitch_press_cnt0", press_cnt[0] - b, 0, 0);

    // ch1 hold until two repeats, then release
    b = press_cnt[1]; br = rep_cnt[1];
    btn[1] = 1'b1; t0 = cyc;
    for (i = 0; i < 200 && rep_cnt[1] < br + 2; i++) step(1);
    want("ch1_two_repeats_seen", rep_cnt[1] - br, 2, 2);
    want("ch1_press_cnt", press_cnt[1] - b, 1, 1);
    want("ch1_press_latency", last_press[1] - t0, 22, 34);
    want("ch1_first_repeat_gap", first_rep_gap[1], 50, 50);
    want("ch1_repeat_period", rep_gap[1], 20, 20);
    bl = rel_cnt[1];
    btn[1] = 1'b0; t0 = cyc;
    for (i = 0; i < 60 && rel_cnt[1] == bl; i++) step(1);
    want("ch1_release_latency", last_rel[1] - t0, 22, 34);
    snap = rep_cnt[1];
    step(100);
    want("ch1_release_cnt", rel_cnt[1] - bl, 1, 1);
    want("ch1_repeats_after_release", rep_cnt[1] - snap, 0, 0);

    // chattering ch2
    b = press_cnt[2];
    for (int k = 0; k < 14; k++) begin btn[2] = ~btn[2]; step(7); end
    btn[2] = 1'b1; t0 = cyc;
    for (i = 0; i < 60 && press_cnt[2] == b; i++) step(1);
    step(10);
    want("ch2_chatter_press_cnt", press_cnt[2] - b, 1, 1);
    want("ch2_chatter_latency", last_press[2] - t0, 22, 34);
    btn[2] = 1'b0; step(60);

    // all channels together, then reset while repeating
    for (int c = 0; c < N; c++) begin bp[c] = press_cnt[c]; brp[c] = rep_cnt[c]; end
    btn = '1;
    step(120);
    for (int c = 0; c < N; c++) begin
      want("all_press_cnt", press_cnt[c] - bp[c], 1, 1);
      want("all_first_repeat_gap", first_rep_gap[c], 50, 50);
      want("all_same_press_cycle", last_press[c] - last_press[0], 0, 0);
      want("all_same_repeat_cnt", (rep_cnt[c] - brp[c]) - (rep_cnt[0] - brp[0]), 0, 0);
    end
    rst = 1'b1; btn = '0;
    snap = rep_cnt[0];
    step(3);
    rst = 1'b0;
    step(10);
    want("reset_stops_repeats", rep_cnt[0] - snap, 0, 0);
    for (int c = 0; c < N; c++) bp[c] = press_cnt[c];
    btn = '1; t0 = cyc;
    step(100);
    for (int c = 0; c < N; c++) begin
      want("repress_cnt", press_cnt[c] - bp[c], 1, 1);
      want("repress_latency", last_press[c] - t0, 22, 34);
      want("repress_first_repeat_gap", first_rep_gap[c], 50, 50);
    end
    btn = '0; step(60);

    // random levels with random hold lengths (bouncy and long)
    for (int c = 0; c < N; c++) tmr[c] = 0;
    for (int k = 0; k < 1500; k++) begin
      for (int c = 0; c < N; c++) begin
        if (tmr[c] == 0) begin
          btn[c] = 1'($urandom_range(0, 1));
          tmr[c] = ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 8))
                                               : int'($urandom_range(20, 120));
        end else tmr[c]--;
      end
      step(1);
    end
    btn = '0;
    step(80);
    want("scoreboard_drained", sb.size(), 0, 0);
    step(3);
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
